regfile_arbiter: RTL and testbench
==================================

REGFILE_ARBITER -- requirements
Module: regfile_arbiter

Interface
REQ-001 Parameters: none; address width fixed at 5 (32 entries), data width fixed at 8.
REQ-002 Clock and reset: one clock; reset is asynchronous and active-low.
REQ-003 clk  in  1  system clock; all controller state on rising edge.
REQ-004 rst_n  in  1  asynchronous active-low reset.
REQ-005 a_valid  in  1  requester A command valid.
REQ-006 a_we  in  1  A command type: 1 = write, 0 = read.
REQ-007 a_addr  in  5  A register index.
REQ-008 a_wdata  in  8  A write data.
REQ-009 a_ready  out  1  A command accepted this cycle.
REQ-010 a_done  out  1  A command completed; one-cycle pulse.
REQ-011 a_rdata  out  8  A read result; valid when a_done is high for a read.
REQ-012 b_valid, b_we, b_addr, b_wdata, b_ready, b_done, b_rdata: same directions, widths and meanings for requester B.
REQ-013 rf_address  out  5  register file address.
REQ-014 rf_data_in  out  8  register file write data.
REQ-015 rf_enable  out  1  register file write enable; the file writes on the falling clk edge.
REQ-016 rf_data_out  in  8  register file combinational read data.

Function
REQ-017 FSM states: IDLE, ACCESS, DONE; one command in flight at a time.
REQ-018 IDLE, one requester valid: that requester wins.
REQ-019 IDLE, both valid: round-robin; the winner is the requester not served last; last_grant updates on each handshake.
REQ-020 x_ready is combinational: high only in IDLE, for the winner only; never both high.
REQ-021 Handshake: the command is accepted at the rising edge where x_valid && x_ready; we, addr and wdata are latched at that edge; next state is ACCESS.
REQ-022 Before acceptance, the requester holds valid and command fields stable; valid dropped before ready has no effect.
REQ-023 ACCESS, one cycle: rf_address = latched addr and rf_data_in = latched wdata, stable for the whole cycle; rf_enable = latched we.
REQ-024 rf_enable, rf_address and rf_data_in are registered outputs, glitch-free across the falling edge on which the write lands.
REQ-025 ACCESS, read: rf_data_out is captured into the winner's rdata register at the end of ACCESS.
REQ-026 DONE, one cycle: the winner's x_done = 1, the other requester's done = 0; next state is IDLE.
REQ-027 Latency: accept at edge N; ACCESS in cycle N..N+1; x_done high in cycle N+1..N+2; next acceptance possible at edge N+3.
REQ-028 x_rdata holds its value until the next read completes for that requester; writes leave x_rdata unchanged.
REQ-029 Outside ACCESS: rf_enable = 0, rf_address = 0, rf_data_in = 0.
REQ-030 Any address 0..31 is legal; no wrap or range checks; a write followed by a read of the same address returns the new data.
REQ-031 New valid inputs during ACCESS or DONE are ignored (ready = 0) and are arbitrated in the next IDLE.

Reset
REQ-032 rst_n low forces immediately: state = IDLE; last_grant = B, so A wins the first tie; rf_enable = 0; rf_address = 0; rf_data_in = 0; a_done = b_done = 0; a_rdata = b_rdata = 0.
REQ-033 Reset during ACCESS aborts the command: no done pulse is issued; rf_enable drops asynchronously, so no write occurs at the following falling edge if reset is asserted before it.
REQ-034 After rst_n rises, the first acceptance happens no earlier than the first rising edge with rst_n high.

Verification
REQ-035 A writes 0x5A to addr 3, then reads addr 3 -> rf_enable high for exactly one cycle with rf_address=3 and rf_data_in=0x5A; read yields a_rdata=0x5A with a_done at N+1; b_done stays 0.
REQ-036 After reset, A and B valid in the same cycle, both held for 4 commands -> grant order A,B,A,B; ready never high for both; each done 3 cycles apart.
REQ-037 B reads addr 29 after power-up (regfile initialised to 0xFF) -> b_rdata=0xFF; a_rdata unchanged at 0.
REQ-038 A valid during ACCESS of a B write -> a_ready stays 0 until IDLE; A is accepted at B's DONE+1 edge.
REQ-039 rst_n pulsed low mid-ACCESS of a write of 0x11 to addr 7 -> rf_enable=0 immediately, no done pulse, and a later read of addr 7 returns the prior value.
REQ-040 Back-to-back reads of addr 0 and addr 31 by A -> a_rdata sequence 0x00 then 0xFF; throughput is one command per 3 cycles.

Source files
------------

// File: rtl/regfile_arbiter.sv
// Two-requester round-robin arbiter in front of a 32x8 register file that writes on the falling clock edge.
// Each command runs IDLE -> ACCESS -> DONE, so a new command can be accepted at most once every three cycles.
module regfile_arbiter (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       a_valid,
    input  logic       a_we,
    input  logic [4:0] a_addr,
    input  logic [7:0] a_wdata,
    output logic       a_ready,
    output logic       a_done,
    output logic [7:0] a_rdata,
    input  logic       b_valid,
    input  logic       b_we,
    input  logic [4:0] b_addr,
    input  logic [7:0] b_wdata,
    output logic       b_ready,
    output logic       b_done,
    output logic [7:0] b_rdata,
    output logic [4:0] rf_address,
    output logic [7:0] rf_data_in,
    output logic       rf_enable,
    input  logic [7:0] rf_data_out
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } state_t;

    state_t     state_q, state_d;
    logic       last_b_q, last_b_d;     // 1 = B was granted most recently
    logic       owner_b_q, owner_b_d;   // requester that owns the command in flight
    logic       we_q, we_d;
    logic       rf_enable_q, rf_enable_d;
    logic [4:0] rf_address_q, rf_address_d;
    logic [7:0] rf_data_in_q, rf_data_in_d;
    logic [7:0] a_rdata_q, a_rdata_d;
    logic [7:0] b_rdata_q, b_rdata_d;

    logic win_b;
    logic grant_a;
    logic grant_b;

    // On a tie the requester not served last wins; a lone requester always wins.
    assign win_b   = b_valid && (!a_valid || !last_b_q);
    assign grant_a = (state_q == IDLE) && a_valid && !win_b;
    assign grant_b = (state_q == IDLE) && win_b;

    always_comb begin
        state_d      = state_q;
        last_b_d     = last_b_q;
        owner_b_d    = owner_b_q;
        we_d         = we_q;
        rf_enable_d  = rf_enable_q;
        rf_address_d = rf_address_q;
        rf_data_in_d = rf_data_in_q;
        a_rdata_d    = a_rdata_q;
        b_rdata_d    = b_rdata_q;

        case (state_q)
            IDLE: begin
                if (grant_a || grant_b) begin
                    state_d      = ACCESS;
                    owner_b_d    = grant_b;
                    last_b_d     = grant_b;
                    we_d         = grant_b ? b_we    : a_we;
                    rf_enable_d  = grant_b ? b_we    : a_we;
                    rf_address_d = grant_b ? b_addr  : a_addr;
                    rf_data_in_d = grant_b ? b_wdata : a_wdata;
                end
            end
            ACCESS: begin
                // Bus returns to zero as the access ends; read data is captured on the same edge.
                state_d      = DONE;
                rf_enable_d  = 1'b0;
                rf_address_d = 5'd0;
                rf_data_in_d = 8'd0;
                if (!we_q) begin
                    if (owner_b_q) begin
                        b_rdata_d = rf_data_out;
                    end else begin
                        a_rdata_d = rf_data_out;
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            last_b_q     <= 1'b1;
            owner_b_q    <= 1'b0;
            we_q         <= 1'b0;
            rf_enable_q  <= 1'b0;
            rf_address_q <= 5'd0;
            rf_data_in_q <= 8'd0;
            a_rdata_q    <= 8'd0;
            b_rdata_q    <= 8'd0;
        end else begin
            state_q      <= state_d;
            last_b_q     <= last_b_d;
            owner_b_q    <= owner_b_d;
            we_q         <= we_d;
            rf_enable_q  <= rf_enable_d;
            rf_address_q <= rf_address_d;
            rf_data_in_q <= rf_data_in_d;
            a_rdata_q    <= a_rdata_d;
            b_rdata_q    <= b_rdata_d;
        end
    end

    assign a_ready    = grant_a;
    assign b_ready    = grant_b;
    assign a_done     = (state_q == DONE) && !owner_b_q;
    assign b_done     = (state_q == DONE) && owner_b_q;
    assign a_rdata    = a_rdata_q;
    assign b_rdata    = b_rdata_q;
    assign rf_enable  = rf_enable_q;
    assign rf_address = rf_address_q;
    assign rf_data_in = rf_data_in_q;

endmodule

// File: tb/tb_regfile_arbiter.sv
// Directed bench for regfile_arbiter with a falling-edge-write register file model initialised to 0xFF.
module tb_regfile_arbiter;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       a_valid = 1'b0, a_we = 1'b0;
    logic [4:0] a_addr = 5'd0;
    logic [7:0] a_wdata = 8'd0;
    logic       a_ready, a_done;
    logic [7:0] a_rdata;
    logic       b_valid = 1'b0, b_we = 1'b0;
    logic [4:0] b_addr = 5'd0;
    logic [7:0] b_wdata = 8'd0;
    logic       b_ready, b_done;
    logic [7:0] b_rdata;
    logic [4:0] rf_address;
    logic [7:0] rf_data_in;
    logic       rf_enable;
    logic [7:0] rf_data_out;

    logic [7:0] mem [32];
    int n_vec = 0;
    int n_err = 0;
    logic [7:0] exp_a = 8'd0;
    logic [7:0] exp_b = 8'd0;

    always #5 clk = ~clk;

    initial begin
        for (int i = 0; i < 32; i++) mem[i] = 8'hFF;
    end
    always @(negedge clk) begin
        if (rf_enable) mem[rf_address] <= rf_data_in;
    end
    assign rf_data_out = mem[rf_address];

    regfile_arbiter dut (
        .clk(clk), .rst_n(rst_n),
        .a_valid(a_valid), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata),
        .a_ready(a_ready), .a_done(a_done), .a_rdata(a_rdata),
        .b_valid(b_valid), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata),
        .b_ready(b_ready), .b_done(b_done), .b_rdata(b_rdata),
        .rf_address(rf_address), .rf_data_in(rf_data_in),
        .rf_enable(rf_enable), .rf_data_out(rf_data_out)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        a_valid = 1'b0;
        b_valid = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        check("rst_rf_enable", 32'(rf_enable), 0);
        check("rst_rf_address", 32'(rf_address), 0);
        check("rst_rf_data_in", 32'(rf_data_in), 0);
        check("rst_dones", 32'({a_done, b_done}), 0);
        check("rst_a_rdata", 32'(a_rdata), 0);
        check("rst_b_rdata", 32'(b_rdata), 0);
        rst_n = 1'b1;
        exp_a = 8'd0;
        exp_b = 8'd0;
    endtask

    // Issue one command from an idle arbiter and check every phase of it.
    task automatic run_cmd(input logic sel, input logic we, input logic [4:0] addr,
                           input logic [7:0] wdata, input logic [7:0] exp_rd, output time t_acc);
        logic rdy;
        t_acc = 0;
        if (sel) begin
            b_valid = 1'b1; b_we = we; b_addr = addr; b_wdata = wdata;
        end else begin
            a_valid = 1'b1; a_we = we; a_addr = addr; a_wdata = wdata;
        end
        #1;
        rdy = sel ? b_ready : a_ready;
        for (int w = 0; w < 8 && !rdy; w++) begin
            @(negedge clk); #1;
            rdy = sel ? b_ready : a_ready;
        end
        check("ready_winner", 32'(rdy), 1);
        if (!rdy) begin
            a_valid = 1'b0;
            b_valid = 1'b0;
            return;
        end
        check("ready_other", 32'(sel ? a_ready : b_ready), 0);
        @(posedge clk);
        t_acc = $time;
        #1;
        a_valid = 1'b0;
        b_valid = 1'b0;
        @(negedge clk); #1;
        check("access_rf_enable", 32'(rf_enable), 32'(we));
        check("access_rf_address", 32'(rf_address), 32'(addr));
        check("access_rf_data_in", 32'(rf_data_in), 32'(wdata));
        check("access_dones", 32'({a_done, b_done}), 0);
        @(negedge clk); #1;
        check("done_winner", 32'(sel ? b_done : a_done), 1);
        check("done_other", 32'(sel ? a_done : b_done), 0);
        check("done_rf_bus", 32'({rf_enable, rf_address, rf_data_in}), 0);
        if (!we) begin
            if (sel) exp_b = exp_rd; else exp_a = exp_rd;
        end
        check("a_rdata", 32'(a_rdata), 32'(exp_a));
        check("b_rdata", 32'(b_rdata), 32'(exp_b));
        @(negedge clk); #1;
        check("idle_dones", 32'({a_done, b_done}), 0);
    endtask

    typedef struct {
        logic       sel;
        logic       we;
        logic [4:0] addr;
        logic [7:0] wdata;
        logic [7:0] exp_rd;
    } vec_t;

    vec_t vecs [11];
    time  t_now, t_prev;
    int   grants [4];
    int   ng, nga, ngb, nd, last_done;
    logic saw_done;

    initial begin
        vecs[0]  = '{1'b1, 1'b0, 5'd29, 8'h00, 8'hFF};
        vecs[1]  = '{1'b0, 1'b1, 5'd3,  8'h5A, 8'h00};
        vecs[2]  = '{1'b0, 1'b0, 5'd3,  8'h00, 8'h5A};
        vecs[3]  = '{1'b0, 1'b1, 5'd0,  8'h00, 8'h00};
        vecs[4]  = '{1'b0, 1'b0, 5'd0,  8'h00, 8'h00};
        vecs[5]  = '{1'b0, 1'b0, 5'd31, 8'h00, 8'hFF};
        vecs[6]  = '{1'b1, 1'b1, 5'd31, 8'hC3, 8'h00};
        vecs[7]  = '{1'b0, 1'b0, 5'd31, 8'h00, 8'hC3};
        vecs[8]  = '{1'b1, 1'b0, 5'd3,  8'h00, 8'h5A};
        vecs[9]  = '{1'b0, 1'b1, 5'd3,  8'hA5, 8'h00};
        vecs[10] = '{1'b1, 1'b0, 5'd3,  8'h00, 8'hA5};

        do_reset();
        t_prev = 0;
        for (int i = 0; i < 11; i++) begin
            run_cmd(vecs[i].sel, vecs[i].we, vecs[i].addr, vecs[i].wdata, vecs[i].exp_rd, t_now);
            $display("vec %0d: sel=%0d we=%0d addr=%0d wdata=0x%0h a_rdata=0x%0h b_rdata=0x%0h",
                     i, vecs[i].sel, vecs[i].we, vecs[i].addr, vecs[i].wdata, a_rdata, b_rdata);
            if (i > 0) check("throughput", 32'(t_now - t_prev), 30);
            t_prev = t_now;
        end

        // A requests during B's write; it must wait until the next IDLE.
        b_valid = 1'b1; b_we = 1'b1; b_addr = 5'd10; b_wdata = 8'h33;
        #1 check("b_ready_alone", 32'(b_ready), 1);
        @(posedge clk); #1 b_valid = 1'b0;
        @(negedge clk);
        a_valid = 1'b1; a_we = 1'b0; a_addr = 5'd10; a_wdata = 8'h00;
        #1 check("a_ready_in_access", 32'(a_ready), 0);
        check("b_write_enable", 32'({rf_enable, rf_address}), 32'({1'b1, 5'd10}));
        @(negedge clk); #1;
        check("a_ready_in_done", 32'(a_ready), 0);
        check("b_done_pulse", 32'({a_done, b_done}), 32'(2'b01));
        @(negedge clk); #1;
        check("a_ready_next_idle", 32'(a_ready), 1);
        @(posedge clk); #1 a_valid = 1'b0;
        @(negedge clk);
        @(negedge clk); #1;
        check("a_done_after_wait", 32'(a_done), 1);
        check("a_rdata_after_wait", 32'(a_rdata), 32'h33);
        $display("wait seq: a_rdata=0x%0h", a_rdata);
        @(negedge clk);

        // Tie after reset: A first, then alternate.
        do_reset();
        @(negedge clk);
        a_valid = 1'b1; a_we = 1'b0; a_addr = 5'd3;
        b_valid = 1'b1; b_we = 1'b0; b_addr = 5'd31;
        ng = 0; nga = 0; ngb = 0; nd = 0; last_done = -1;
        for (int cyc = 0; cyc < 40 && nd < 4; cyc++) begin
            #1;
            if (a_ready && b_ready) check("ready_exclusive", 32'({a_ready, b_ready}), 32'(2'b10));
            if (a_done || b_done) begin
                if (last_done >= 0) check("done_spacing", 32'(cyc - last_done), 3);
                last_done = cyc;
                nd++;
            end
            if (a_ready && ng < 4) begin grants[ng] = 0; ng++; nga++; end
            else if (b_ready && ng < 4) begin grants[ng] = 1; ng++; ngb++; end
            @(negedge clk);
            if (nga == 2) a_valid = 1'b0;
            if (ngb == 2) b_valid = 1'b0;
        end
        a_valid = 1'b0;
        b_valid = 1'b0;
        check("tie_grant_count", 32'(ng), 4);
        check("tie_done_count", 32'(nd), 4);
        if (ng == 4) begin
            check("tie_order0", 32'(grants[0]), 0);
            check("tie_order1", 32'(grants[1]), 1);
            check("tie_order2", 32'(grants[2]), 0);
            check("tie_order3", 32'(grants[3]), 1);
            $display("tie seq: grants %0d %0d %0d %0d", grants[0], grants[1], grants[2], grants[3]);
        end
        check("tie_a_rdata", 32'(a_rdata), 32'hA5);
        check("tie_b_rdata", 32'(b_rdata), 32'hC3);

        // Reset in the middle of a write to addr 7 must cancel it.
        do_reset();
        @(negedge clk);
        a_valid = 1'b1; a_we = 1'b1; a_addr = 5'd7; a_wdata = 8'h11;
        #1 check("abort_a_ready", 32'(a_ready), 1);
        @(posedge clk); #1 a_valid = 1'b0;
        check("abort_enable_before", 32'(rf_enable), 1);
        #1 rst_n = 1'b0;
        #1 check("abort_bus_cleared", 32'({rf_enable, rf_address, rf_data_in}), 0);
        @(negedge clk); #2 rst_n = 1'b1;
        saw_done = 1'b0;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk); #1;
            if (a_done || b_done) saw_done = 1'b1;
        end
        check("abort_no_done", 32'(saw_done), 0);
        exp_a = 8'd0;
        exp_b = 8'd0;
        run_cmd(1'b0, 1'b0, 5'd7, 8'h00, 8'hFF, t_now);
        $display("abort seq: read addr 7 a_rdata=0x%0h", a_rdata);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule
